// File: rtl/seg7_pkg.sv
// Seven-segment constants shared by the display driver and the capture side.
// Patterns are active-low, with bit0 = segment a and bit6 = segment g.
package seg7_pkg;

    localparam int SEG_A_IDX = 0;
    localparam int SEG_B_IDX = 1;
    localparam int SEG_C_IDX = 2;
    localparam int SEG_D_IDX = 3;
    localparam int SEG_E_IDX = 4;
    localparam int SEG_F_IDX = 5;
    localparam int SEG_G_IDX = 6;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Driver-side encoder; the decoder below is its exact inverse.
    function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_HEX_A;
            4'hB:    return SEG_HEX_B;
            4'hC:    return SEG_HEX_C;
            4'hD:    return SEG_HEX_D;
            4'hE:    return SEG_HEX_E;
            default: return SEG_HEX_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
// Any pattern outside the 16-entry table (blank included) reports o_valid = 0.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_valid
);

    always_comb begin
        // NOTE: default every output first so no path through the case infers a latch.
        o_nibble = 4'h0;
        o_valid  = 1'b1;
        case (i_seg)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_HEX_A: o_nibble = 4'hA;
            SEG_HEX_B: o_nibble = 4'hB;
            SEG_HEX_C: o_nibble = 4'hC;
            SEG_HEX_D: o_nibble = 4'hD;
            SEG_HEX_E: o_nibble = 4'hE;
            SEG_HEX_F: o_nibble = 4'hF;
            default:   o_valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_mux_capture.sv
// Recovers the four hex digits from a multiplexed seven-segment display bus,
// capturing each digit once per stable dwell and pulsing frame_valid per full frame.
module seg_mux_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       AN0,
    input  logic       AN1,
    input  logic       AN2,
    input  logic       AN3,
    input  logic [6:0] LEDin,
    output logic [3:0] SN0,
    output logic [3:0] SN1,
    output logic [3:0] SN2,
    output logic [3:0] SN3,
    output logic [3:0] digit_err,
    output logic       frame_valid
);

    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(STABLE_CYCLES - 1);

    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic [3:0]       r_an_d;
    logic [6:0]       r_seg_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_captured;
    logic [3:0]       r_seen;
    logic [3:0]       r_sn [4];
    logic [3:0]       r_err;
    logic             r_frame;

    logic       w_an_legal;
    logic [1:0] w_sel;
    logic       w_changed;
    logic       w_capture;
    logic [3:0] w_seen_next;
    logic [3:0] w_nibble;
    logic       w_valid;

    seg7_decode u_decode (
        .i_seg    (r_seg),
        .o_nibble (w_nibble),
        .o_valid  (w_valid)
    );

    // Exactly one strobe low selects a digit; anything else is treated as idle.
    always_comb begin
        w_an_legal = 1'b1;
        w_sel      = 2'd0;
        case (r_an)
            4'b1110: w_sel = 2'd0;
            4'b1101: w_sel = 2'd1;
            4'b1011: w_sel = 2'd2;
            4'b0111: w_sel = 2'd3;
            default: w_an_legal = 1'b0;
        endcase
    end

    assign w_changed   = (r_an != r_an_d) || (r_seg != r_seg_d);
    assign w_capture   = w_an_legal && !w_changed && (r_cnt == CNT_TGT) && !r_captured;
    assign w_seen_next = r_seen | (4'b0001 << w_sel);

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; the small digit array is reset like any other flop.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_an       <= '0;
            r_seg      <= '0;
            r_an_d     <= '0;
            r_seg_d    <= '0;
            r_cnt      <= '0;
            r_captured <= 1'b0;
            r_seen     <= '0;
            r_err      <= '0;
            r_frame    <= 1'b0;
            for (int k = 0; k < 4; k++) r_sn[k] <= '0;
        end else begin
            r_an    <= {AN3, AN2, AN1, AN0};
            r_seg   <= LEDin;
            r_an_d  <= r_an;
            r_seg_d <= r_seg;
            r_frame <= 1'b0;

            if (!w_an_legal || w_changed) begin
                r_cnt      <= '0;
                r_captured <= 1'b0;
            end else begin
                if (r_cnt != CNT_TGT) r_cnt <= r_cnt + 1'b1;
                if (w_capture) begin
                    r_captured <= 1'b1;
                    r_err[w_sel] <= !w_valid;
                    if (w_valid) r_sn[w_sel] <= w_nibble;
                    if (w_seen_next == 4'b1111) begin
                        r_frame <= 1'b1;
                        r_seen  <= '0;
                    end else begin
                        r_seen  <= w_seen_next;
                    end
                end
            end
        end
    end

    assign SN0         = r_sn[0];
    assign SN1         = r_sn[1];
    assign SN2         = r_sn[2];
    assign SN3         = r_sn[3];
    assign digit_err   = r_err;
    assign frame_valid = r_frame;

endmodule

// File: tb/tb_seg_mux_capture.sv
// Directed self-checking bench for seg_mux_capture with STABLE_CYCLES = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_mux_capture;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       AN0 = 1'b1, AN1 = 1'b1, AN2 = 1'b1, AN3 = 1'b1;
    logic [6:0] LEDin = 7'b1111111;
    logic [3:0] SN0, SN1, SN2, SN3, digit_err;
    logic       frame_valid;

    int n_checks = 0;
    int n_errors = 0;
    int fv_count = 0;

    localparam logic [6:0] P_0 = 7'b1000000;
    localparam logic [6:0] P_1 = 7'b1111001;
    localparam logic [6:0] P_3 = 7'b0110000;
    localparam logic [6:0] P_5 = 7'b0010010;
    localparam logic [6:0] P_6 = 7'b0000010;
    localparam logic [6:0] P_8 = 7'b0000000;
    localparam logic [6:0] P_A = 7'b0001000;
    localparam logic [6:0] P_F = 7'b0001110;
    localparam logic [6:0] P_BLANK = 7'b1111111;
    localparam logic [6:0] P_BAD   = 7'b1010101;

    seg_mux_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .AN0         (AN0),
        .AN1         (AN1),
        .AN2         (AN2),
        .AN3         (AN3),
        .LEDin       (LEDin),
        .SN0         (SN0),
        .SN1         (SN1),
        .SN2         (SN2),
        .SN3         (SN3),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) if (frame_valid) fv_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one anode/segment combination for n rising edges (call from a falling edge).
    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        {AN3, AN2, AN1, AN0} = an;
        LEDin = seg;
        repeat (n) @(negedge clk_in);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv_base;
        repeat (3) @(negedge clk_in);
        check("rst_sn0", SN0, 4'h0);
        check("rst_sn3", SN3, 4'h0);
        check("rst_err", digit_err, 4'h0);
        check("rst_fv",  frame_valid, 1'b0);
        rst = 1'b0;
        hold(4'b1111, P_BLANK, 3);

        // Normal frame, AN3 dwell stepped cycle by cycle to locate the pulse.
        hold(4'b1110, P_3, 8);
        hold(4'b1101, P_A, 8);
        hold(4'b1011, P_0, 8);
        hold(4'b0111, P_F, 5);
        check("frm_pre_fv",  frame_valid, 1'b0);
        check("frm_pre_sn3", SN3, 4'h0);
        @(negedge clk_in);
        check("frm_fv_high", frame_valid, 1'b1);
        check("frm_sn3",     SN3, 4'hF);
        @(negedge clk_in);
        check("frm_fv_low",  frame_valid, 1'b0);
        hold(4'b0111, P_F, 1);
        check("frm_sn0", SN0, 4'h3);
        check("frm_sn1", SN1, 4'hA);
        check("frm_sn2", SN2, 4'h0);
        check("frm_err", digit_err, 4'h0);
        check("frm_cnt", fv_count, 1);

        // Glitch filter: 4-cycle dwell ignored, 5-cycle dwell captured.
        hold(4'b1101, P_1, 4);
        hold(4'b1111, P_BLANK, 3);
        check("glitch_short", SN1, 4'hA);
        hold(4'b1101, P_1, 5);
        hold(4'b1111, P_BLANK, 2);
        check("glitch_long", SN1, 4'h1);

        // Illegal anode combinations never capture.
        hold(4'b1100, P_8, 20);
        hold(4'b1111, P_8, 20);
        check("illeg_sn0", SN0, 4'h3);
        check("illeg_sn2", SN2, 4'h0);
        check("illeg_fv",  fv_count, 1);

        // Undecodable patterns on digit 2 keep the old nibble and set the error bit.
        hold(4'b1011, P_5, 8);
        check("inv_pre_sn2", SN2, 4'h5);
        hold(4'b1011, P_BLANK, 8);
        check("inv_blank_sn2", SN2, 4'h5);
        check("inv_blank_err", digit_err, 4'b0100);
        hold(4'b1011, P_BAD, 8);
        check("inv_bad_sn2", SN2, 4'h5);
        check("inv_bad_err", digit_err, 4'b0100);
        hold(4'b1011, P_6, 8);
        check("inv_fix_sn2", SN2, 4'h6);
        check("inv_fix_err", digit_err, 4'b0000);

        // Partial frame: repeats do not advance; digit 3 completes, then seen restarts.
        fv_base = fv_count;
        hold(4'b1110, P_0, 8);
        hold(4'b1101, P_1, 8);
        hold(4'b1110, P_8, 8);
        hold(4'b1101, P_A, 8);
        hold(4'b1011, P_3, 8);
        check("part_no_fv", fv_count, fv_base);
        check("part_sn0",   SN0, 4'h8);
        hold(4'b0111, P_5, 8);
        check("part_fv",    fv_count, fv_base + 1);
        check("part_sn3",   SN3, 4'h5);
        hold(4'b1110, P_1, 8);
        hold(4'b1101, P_3, 8);
        hold(4'b1011, P_F, 8);
        check("part_cleared", fv_count, fv_base + 1);
        hold(4'b0111, P_6, 8);
        check("part_fv2",   fv_count, fv_base + 2);

        // Reset mid-dwell clears outputs immediately; capture resumes 6 edges later.
        hold(4'b1110, P_3, 2);
        #2 rst = 1'b1;
        #1;
        check("mrst_sn0", SN0, 4'h0);
        check("mrst_sn1", SN1, 4'h0);
        check("mrst_sn3", SN3, 4'h0);
        check("mrst_err", digit_err, 4'h0);
        check("mrst_fv",  frame_valid, 1'b0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        repeat (5) @(negedge clk_in);
        check("mrst_no_cap", SN0, 4'h0);
        @(negedge clk_in);
        check("mrst_cap", SN0, 4'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_mux_capture.md
Name: seg_mux_capture

Overview:
- Receive-side counterpart of the team's 4-digit multiplexed seven-segment driver.
- Watches the time-multiplexed anode strobes (AN0..AN3) and the shared segment bus, and recovers the four hex digits being displayed.
- Rejects transient or ghost patterns with a stability filter, flags undecodable patterns, and reports when a full refresh frame has been captured.
- Used in lab self-check and board-loopback tests of display-driving designs.

Parameters:
- STABLE_CYCLES, 4, consecutive clk_in cycles an anode/segment combination must hold before it is captured (legal range 2..255).
- CNT_W, 8, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- AN0  input  1  digit-0 anode strobe, active-low.
- AN1  input  1  digit-1 anode strobe, active-low.
- AN2  input  1  digit-2 anode strobe, active-low.
- AN3  input  1  digit-3 anode strobe, active-low.
- LEDin  input  7  segment bus, active-low; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- SN0  output  4  last valid nibble captured for digit 0.
- SN1  output  4  last valid nibble captured for digit 1.
- SN2  output  4  last valid nibble captured for digit 2.
- SN3  output  4  last valid nibble captured for digit 3.
- digit_err  output  4  bit k set when the last capture on digit k was undecodable.
- frame_valid  output  1  one-cycle pulse when all four digits have been captured since the previous pulse or reset.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - SN0..SN3 = 0, digit_err = 0, frame_valid = 0.
  - Input register, stability counter, captured flag and seen mask all cleared.
- Input stage: {AN3..AN0, LEDin} registered once on clk_in into r_an/r_seg. All further logic works on the registered copy and its previous-cycle value.
- Anode legality: r_an must have exactly one bit low. Zero or more than one low counts as idle:
  - counter = 0, captured flag = 0, no capture.
- Stability counter:
  - Cleared, along with the captured flag, whenever r_an or r_seg differs from its previous-cycle value, or anodes are illegal.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- Capture: occurs on the cycle the counter equals STABLE_CYCLES-1 and the captured flag is 0; the flag is then set. Exactly one capture per dwell.
  - Valid pattern: SN_k <= decoded nibble, digit_err[k] <= 0.
  - Invalid pattern, including blank 7'h7F: SN_k holds its value, digit_err[k] <= 1.
  - Either way, seen[k] <= 1.
- Latency: pins held constant from edge t yield updated SN_k/digit_err after the edge at t+STABLE_CYCLES+1. Dwells shorter than STABLE_CYCLES+1 cycles are never captured.
- Frame handling:
  - When a capture makes seen == 4'b1111, frame_valid pulses high for exactly that one registered cycle and seen clears to 0 in the same cycle.
  - Re-capturing a digit already in seen only updates its value; it does not advance the frame.
- Decode table (active-low, g..a order): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Any other pattern is invalid.
- Simultaneous events: a change in the inputs on the same cycle the counter would reach its target takes priority; the counter is cleared and no capture occurs.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16 segment-pattern constants;
  - the SEG_BLANK constant;
  - the segment bit-index constants.
- One combinational sub-module, seg7_decode: 7-bit pattern in, 4-bit nibble plus valid out. The driver side reuses the same package constants.

Test Plan:
- Reset mid-dwell: assert rst while AN=1110, LEDin=0110000 is held -> all outputs 0 on the same cycle; no capture until 5 edges after rst falls.
- Normal frame (STABLE_CYCLES=4): cycle AN0..AN3 with patterns 3, A, 0, F, 8 cycles each -> SN0=3, SN1=A, SN2=0, SN3=F, digit_err=0; frame_valid pulses once, on the AN3 capture cycle.
- Glitch filter: AN=1101, LEDin=1111001 held 4 cycles, then changed -> SN1 unchanged; the same pattern held 5 cycles -> SN1=1.
- Illegal anodes: AN=1100 or 1111 with any LEDin held 20 cycles -> no capture, seen unchanged, no frame_valid.
- Invalid pattern: digit 2 shows 1111111, then 1010101 -> digit_err[2]=1 and SN2 keeps its prior value; a later 0000010 -> SN2=6, digit_err[2]=0.
- Partial frame: digits 0,1,0,1,2 captured -> no pulse; a subsequent digit-3 capture -> a single frame_valid pulse, with seen cleared.
